// File: rtl/lvds_tx_arbiter.sv
// Round-robin arbiter that shares the 32-bit LVDS transmit word channel between NREQ
// requesters, with bounded burst locking and {marker, id, payload} framing.
module lvds_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int PW    = 29,
  parameter int BURST = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               link_up,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*PW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        d_in_tx,
  output logic               enq_tx,
  input  logic               full_n_tx,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic [15:0]        words_sent
);

  localparam int PTRW = (NREQ > 2) ? 2 : 1;
  localparam int CW   = 4;

  typedef enum logic [1:0] {
    ST_DOWN  = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTRW-1:0]   owner_q, owner_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              out_vld_q, out_vld_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       words_q;

  logic              slot_free;
  logic              accept;
  logic              sel_found;
  logic [PTRW-1:0]   sel_idx;
  logic [PTRW-1:0]   acc_idx;
  logic [PTRW-1:0]   cand;
  logic [PW-1:0]     acc_payload;

  // Increment with explicit wrap at NREQ (NREQ need not be a power of two).
  function automatic logic [PTRW-1:0] next_idx(input logic [PTRW-1:0] idx);
    if (int'(idx) >= NREQ - 1) return '0;
    return idx + PTRW'(1);
  endfunction

  function automatic logic [PTRW-1:0] wrap_idx(input logic [PTRW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PTRW'(s);
  endfunction

  assign slot_free  = !out_vld_q || full_n_tx;
  assign enq_tx     = out_vld_q && full_n_tx;
  assign d_in_tx    = data_q;
  assign grant_id   = IDW'(owner_q);
  assign busy       = (state_q == ST_BURST) || out_vld_q;
  assign words_sent = words_q;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    accept      = 1'b0;
    acc_idx     = owner_q;
    req_ready   = '0;
    case (state_q)
      ST_DOWN: begin
        if (link_up) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!link_up) begin
          state_d     = ST_DOWN;
          burst_cnt_d = '0;
        end else if (sel_found && slot_free) begin
          accept      = 1'b1;
          acc_idx     = sel_idx;
          owner_d     = sel_idx;
          burst_cnt_d = CW'(1);
          if (BURST > 1) state_d = ST_BURST;
          else           rr_ptr_d = next_idx(sel_idx);
        end
      end
      ST_BURST: begin
        // Losing the link skips the interrupted owner when arbitration resumes.
        if (!link_up) begin
          state_d     = ST_DOWN;
          burst_cnt_d = '0;
          rr_ptr_d    = next_idx(owner_q);
        end else if (slot_free) begin
          if (req_valid[owner_q]) begin
            accept      = 1'b1;
            burst_cnt_d = burst_cnt_q + CW'(1);
            if (burst_cnt_q == CW'(BURST - 1)) begin
              state_d  = ST_ARB;
              rr_ptr_d = next_idx(owner_q);
            end
          end else begin
            state_d  = ST_ARB;
            rr_ptr_d = next_idx(owner_q);
          end
        end
      end
      default: state_d = ST_DOWN;
    endcase
    if (accept) req_ready[acc_idx] = 1'b1;
  end

  always_comb begin
    acc_payload = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PTRW'(i) == acc_idx) acc_payload = req_data[i*PW +: PW];
    end
  end

  // Output stage: drain and reload can happen in the same cycle.
  always_comb begin
    out_vld_d = out_vld_q && !full_n_tx;
    data_d    = data_q;
    if (accept) begin
      out_vld_d = 1'b1;
      data_d    = {1'b1, IDW'(acc_idx), acc_payload};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_DOWN;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      out_vld_q   <= 1'b0;
      data_q      <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      out_vld_q   <= out_vld_d;
      data_q      <= data_d;
      if (enq_tx) words_q <= words_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// Directed testbench for lvds_tx_arbiter: framing, round-robin bursts, back-pressure,
// link loss, mid-flight reset and counter wrap.
module tb_lvds_tx_arbiter;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int PW    = 29;
  localparam int BURST = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic               link_up;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*PW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        d_in_tx;
  logic               enq_tx;
  logic               full_n_tx;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic [15:0]        words_sent;

  lvds_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .PW(PW), .BURST(BURST)) dut (
    .CLK(CLK), .RST(RST), .link_up(link_up), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .d_in_tx(d_in_tx), .enq_tx(enq_tx), .full_n_tx(full_n_tx),
    .grant_id(grant_id), .busy(busy), .words_sent(words_sent)
  );

  always #5 CLK = ~CLK;

  logic [PW-1:0] base [NREQ];
  int unsigned   cnt  [NREQ];

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*PW +: PW] = base[i] + PW'(cnt[i]);
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [NREQ-1:0] obs_ready;
  logic            obs_enq;
  logic [31:0]     obs_d;
  logic [IDW-1:0]  obs_gid;
  logic            obs_busy;
  logic [15:0]     obs_ws;
  int unsigned     n_enq;
  logic [31:0]     enq_q [$];

  function automatic logic [31:0] frame(input logic [IDW-1:0] id, input logic [PW-1:0] p);
    return {1'b1, id, p};
  endfunction

  // One clock cycle: sample on the falling edge, advance requester data after the rising edge.
  task automatic tick();
    logic [NREQ-1:0] hs;
    @(negedge CLK);
    obs_ready = req_ready;
    obs_enq   = enq_tx;
    obs_d     = d_in_tx;
    obs_gid   = grant_id;
    obs_busy  = busy;
    obs_ws    = words_sent;
    hs        = req_valid & req_ready;
    if (enq_tx) begin
      n_enq++;
      enq_q.push_back(d_in_tx);
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++) if (hs[i]) cnt[i]++;
  endtask

  task automatic do_reset(input logic lu);
    RST       = 1'b1;
    link_up   = lu;
    full_n_tx = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      base[i] = PW'(i) << 20;
      cnt[i]  = 0;
    end
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    n_enq = 0;
    enq_q.delete();
  endtask

  task automatic test_reset();
    int bad;
    do_reset(1'b0);
    req_valid = 4'b1111;
    tick();
    n_checks++; if (obs_d !== 32'h0) begin n_fail++; $display("FAIL reset_d: got %h expected %h", obs_d, 32'h0); end
    n_checks++; if (obs_enq !== 1'b0) begin n_fail++; $display("FAIL reset_enq: got %b expected 0", obs_enq); end
    n_checks++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", obs_ready); end
    n_checks++; if (obs_gid !== 2'd0) begin n_fail++; $display("FAIL reset_gid: got %0d expected 0", obs_gid); end
    n_checks++; if (obs_ws !== 16'd0) begin n_fail++; $display("FAIL reset_ws: got %0d expected 0", obs_ws); end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", obs_busy); end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (obs_ready !== 4'b0000 || obs_enq !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL down_no_grant: got %0d grant cycles expected 0", bad); end
  endtask

  task automatic test_single_req();
    int e;
    do_reset(1'b1);
    base[2]   = 29'h0000123;
    req_valid = 4'b0100;
    tick();
    n_checks++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL single_c0_ready: got %b expected 0000", obs_ready); end
    tick();
    n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL single_c1_ready: got %b expected 0100", obs_ready); end
    tick();
    n_checks++; if (obs_enq !== 1'b1) begin n_fail++; $display("FAIL single_first_enq: got %b expected 1", obs_enq); end
    n_checks++; if (obs_d !== 32'hC0000123) begin n_fail++; $display("FAIL single_first_word: got %h expected %h", obs_d, 32'hC0000123); end
    n_checks++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", obs_busy); end
    n_checks++; if (obs_gid !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d expected 2", obs_gid); end
    e = 1;
    for (int c = 3; c <= 9; c++) begin
      tick();
      if (obs_enq) e++;
      if (c == 6) begin
        n_checks++; if (obs_d !== 32'hC0000127) begin n_fail++; $display("FAIL single_regrant_word: got %h expected %h", obs_d, 32'hC0000127); end
        n_checks++; if (obs_gid !== 2'd2) begin n_fail++; $display("FAIL single_regrant_gid: got %0d expected 2", obs_gid); end
      end
    end
    n_checks++; if (e != 8) begin n_fail++; $display("FAIL single_back_to_back: got %0d enqueues expected 8", e); end
  endtask

  task automatic test_round_robin();
    int idle, bad, hi_bad, r, n, first_bad;
    logic [31:0] exp;
    do_reset(1'b1);
    req_valid = 4'b1111;
    idle = 0;
    for (int c = 0; c < 80 && n_enq < 32; c++) begin
      tick();
      if (n_enq > 0 && n_enq < 32 && !obs_enq) idle++;
    end
    n_checks++;
    if (n_enq < 32) begin
      n_fail++; $display("FAIL rr_timeout: got %0d enqueues expected 32", n_enq);
    end else begin
      tick();
      if (obs_ws !== 16'd32) begin n_fail++; $display("FAIL rr_words_sent: got %0d expected 32", obs_ws); end
      n_checks++; if (idle != 0) begin n_fail++; $display("FAIL rr_idle: got %0d idle cycles expected 0", idle); end
      bad = 0; hi_bad = 0; first_bad = -1;
      for (int k = 0; k < 32; k++) begin
        r   = (k / 4) % 4;
        n   = (k / 16) * 4 + (k % 4);
        exp = frame(IDW'(r), base[r] + PW'(n));
        if (enq_q[k] !== exp) begin bad++; if (first_bad < 0) first_bad = k; end
        if (enq_q[k][31] !== 1'b1) hi_bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rr_sequence: got %0d wrong words (first index %0d) expected 0", bad, first_bad); end
      n_checks++; if (hi_bad != 0) begin n_fail++; $display("FAIL rr_marker: got %0d words without bit31 expected 0", hi_bad); end
    end
  endtask

  task automatic test_backpressure();
    int bad_d, bad_e, bad_r;
    do_reset(1'b1);
    base[1]   = 29'h0001000;
    base[2]   = 29'h0002000;
    req_valid = 4'b0110;
    tick();
    tick();
    n_checks++; if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_grant: got %b expected 0010", obs_ready); end
    tick();
    n_checks++; if (obs_d !== 32'hA0001000 || obs_enq !== 1'b1) begin n_fail++; $display("FAIL bp_word0: got %h/%b expected %h/1", obs_d, obs_enq, 32'hA0001000); end
    full_n_tx = 1'b0;
    bad_d = 0; bad_e = 0; bad_r = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (obs_d !== 32'hA0001001) bad_d++;
      if (obs_enq !== 1'b0) bad_e++;
      if (obs_ready !== 4'b0000) bad_r++;
    end
    n_checks++; if (bad_d != 0) begin n_fail++; $display("FAIL bp_hold_data: got %0d changed cycles expected 0", bad_d); end
    n_checks++; if (bad_e != 0) begin n_fail++; $display("FAIL bp_hold_enq: got %0d enqueue cycles expected 0", bad_e); end
    n_checks++; if (bad_r != 0) begin n_fail++; $display("FAIL bp_hold_ready: got %0d ready cycles expected 0", bad_r); end
    full_n_tx = 1'b1;
    tick();
    n_checks++; if (obs_d !== 32'hA0001001 || obs_enq !== 1'b1 || obs_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release: got %h/%b/%b expected %h/1/0010", obs_d, obs_enq, obs_ready, 32'hA0001001); end
    tick();
    n_checks++; if (obs_d !== 32'hA0001002) begin n_fail++; $display("FAIL bp_word2: got %h expected %h", obs_d, 32'hA0001002); end
    tick();
    n_checks++; if (obs_d !== 32'hA0001003 || obs_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_rotate: got %h/%b expected %h/0100", obs_d, obs_ready, 32'hA0001003); end
    tick();
    n_checks++; if (obs_d !== 32'hC0002000 || obs_gid !== 2'd2) begin n_fail++; $display("FAIL bp_next_owner: got %h/%0d expected %h/2", obs_d, obs_gid, 32'hC0002000); end
  endtask

  task automatic test_link_down();
    do_reset(1'b1);
    base[1]   = 29'h0001000;
    base[2]   = 29'h0002000;
    req_valid = 4'b0110;
    tick();
    tick();
    tick();
    link_up   = 1'b0;
    full_n_tx = 1'b0;
    tick();
    n_checks++; if (obs_ready !== 4'b0000 || obs_enq !== 1'b0) begin n_fail++; $display("FAIL ld_stop: got %b/%b expected 0000/0", obs_ready, obs_enq); end
    full_n_tx = 1'b1;
    tick();
    n_checks++; if (obs_enq !== 1'b1 || obs_d !== 32'hA0001001 || obs_ready !== 4'b0000) begin n_fail++; $display("FAIL ld_drain: got %b/%h/%b expected 1/%h/0000", obs_enq, obs_d, obs_ready, 32'hA0001001); end
    tick();
    n_checks++; if (obs_enq !== 1'b0 || obs_ready !== 4'b0000) begin n_fail++; $display("FAIL ld_idle: got %b/%b expected 0/0000", obs_enq, obs_ready); end
    link_up = 1'b1;
    tick();
    n_checks++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL ld_down_cycle: got %b expected 0000", obs_ready); end
    tick();
    n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL ld_next_owner: got %b expected 0100", obs_ready); end
    tick();
    n_checks++; if (obs_d !== 32'hC0002000 || obs_enq !== 1'b1) begin n_fail++; $display("FAIL ld_resume_word: got %h/%b expected %h/1", obs_d, obs_enq, 32'hC0002000); end
    n_checks++; if (n_enq != 3) begin n_fail++; $display("FAIL ld_total: got %0d enqueues expected 3", n_enq); end
  endtask

  task automatic test_reset_midflight();
    int stray;
    do_reset(1'b1);
    base[0]   = 29'h0000055;
    req_valid = 4'b0001;
    tick();
    tick();
    tick();
    n_checks++; if (obs_d !== 32'h80000055 || obs_enq !== 1'b1) begin n_fail++; $display("FAIL rm_word0: got %h/%b expected %h/1", obs_d, obs_enq, 32'h80000055); end
    full_n_tx = 1'b0;
    tick();
    n_checks++; if (obs_d !== 32'h80000056 || obs_enq !== 1'b0 || obs_ws !== 16'd1) begin n_fail++; $display("FAIL rm_held: got %h/%b/%0d expected %h/0/1", obs_d, obs_enq, obs_ws, 32'h80000056); end
    RST = 1'b1;
    tick();
    RST       = 1'b0;
    full_n_tx = 1'b1;
    req_valid = 4'b0000;
    tick();
    n_checks++; if (obs_enq !== 1'b0 || obs_d !== 32'h0) begin n_fail++; $display("FAIL rm_cleared: got %b/%h expected 0/%h", obs_enq, obs_d, 32'h0); end
    n_checks++; if (obs_ws !== 16'd0 || obs_busy !== 1'b0 || obs_ready !== 4'b0000) begin n_fail++; $display("FAIL rm_state: got %0d/%b/%b expected 0/0/0000", obs_ws, obs_busy, obs_ready); end
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (obs_enq) stray++;
    end
    n_checks++; if (stray != 0 || n_enq != 1) begin n_fail++; $display("FAIL rm_discard: got %0d stray / %0d total expected 0 / 1", stray, n_enq); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    req_valid = 4'b0001;
    for (int c = 0; c < 70000 && n_enq < 65535; c++) tick();
    n_checks++;
    if (n_enq < 65535) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d enqueues expected 65535", n_enq);
    end else begin
      tick();
      if (obs_ws !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full: got %h expected FFFF", obs_ws); end
      for (int c = 0; c < 10 && n_enq < 65536; c++) tick();
      tick();
      n_checks++; if (obs_ws !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", obs_ws); end
    end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_backpressure();
    test_link_down();
    test_reset_midflight();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_tx_arbiter.md
Name: lvds_tx_arbiter

Overview:
- Shares the single 32-bit LVDS transmit word channel (enq/full_n FIFO interface of the LVDS link block) between NREQ requesters.
- Round-robin arbitration with bounded burst locking.
- Frames each word as {1'b1 valid marker, source id, payload}, which the far-end receiver requires before it enqueues a word.
- Sits between the user-side producers and the link's transmit FIFO, in the transmit clock domain.

Parameters:
- NREQ, 4, number of requesters (2..4).
- IDW, 2, source-id field width; IDW+PW must equal 31.
- PW, 29, payload bits per requester word.
- BURST, 4, maximum consecutive words granted to one requester before the grant rotates (1..15).

Ports:
- CLK  in  1  transmit clock (same clock as the link's transmit FIFO).
- RST  in  1  reset; synchronous, active-high.
- link_up  in  1  link aligned and ready; gates new grants.
- req_valid  in  NREQ  per-requester word available.
- req_data  in  NREQ*PW  payloads; requester i occupies bits [i*PW +: PW].
- req_ready  out  NREQ  one-hot or zero; word i accepted on a cycle where req_valid[i] && req_ready[i].
- d_in_tx  out  32  framed word {1'b1, id[IDW-1:0], payload}.
- enq_tx  out  1  enqueue strobe to the link FIFO; equals out_vld && full_n_tx.
- full_n_tx  in  1  link FIFO not full.
- grant_id  out  IDW  current or last owner.
- busy  out  1  state is BURST or out_vld=1.
- words_sent  out  16  count of enq_tx pulses; wraps 0xFFFF->0.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=DOWN, out_vld=0, d_in_tx=0, req_ready=0, enq_tx=0.
  - grant_id=0, rr_ptr=0, burst_cnt=0, words_sent=0.
  - Reset applied mid-burst discards the registered word; it is never sent.
- Output register:
  - A single stage holds out_vld and d_in_tx.
  - It can load when it is empty or when it drains this cycle (out_vld && full_n_tx).
  - This load condition is "slot_free".
- Acceptance:
  - req_ready[i]=1 only when slot_free, link_up=1, i is the selected owner, and state permits.
  - On acceptance at edge k, d_in_tx/out_vld update at k+1. enq_tx is then high in the cycle after k+1 if full_n_tx=1, giving one cycle of latency from accept to enqueue.
- Back-pressure: while full_n_tx=0, d_in_tx is held stable, enq_tx=0, and no new accept occurs.
- State DOWN:
  - No grants.
  - A word already in the output register is still drained when full_n_tx=1.
  - Moves to ARB when link_up=1.
- State ARB:
  - Selects the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NREQ.
  - If one is found and slot_free, accept it: grant_id=i, burst_cnt=1.
  - Next state is BURST if BURST>1, else remain ARB with rr_ptr=i+1 (mod NREQ).
  - No requester: stay in ARB, rr_ptr unchanged.
- State BURST:
  - The owner keeps the grant while req_valid[owner]=1.
  - Each accept increments burst_cnt.
  - When an accept makes burst_cnt==BURST, or the owner deasserts req_valid on a slot_free cycle, go to ARB with rr_ptr=owner+1 (mod NREQ).
  - Stalls from full_n_tx=0 do not count toward BURST.
- link_up falling in ARB or BURST:
  - Go to DOWN at the next edge with burst_cnt=0.
  - rr_ptr advances past the owner, so the interrupted owner does not resume first.
- Simultaneous drain and accept in one cycle: enq_tx pulses for the old word and the new word loads; no bubble.
- Arithmetic:
  - Id field is the requester index truncated to IDW.
  - The rr_ptr wrap is explicit mod NREQ, not a power-of-two assumption.
  - words_sent is a 16-bit free-running increment on enq_tx.
- Requester rule:
  - req_valid must stay high with stable data until accepted.
  - If a requester drops valid before acceptance, it simply loses arbitration; this is not an error.

Test Plan:
1. Reset, link_up=1, full_n_tx=1; requester 2 only, continuous valid with payload 0x0000123 -> accept at edge k; enq_tx at k+2 with d_in_tx=0xC0000123; BURST=4 words back-to-back; grant returns to ARB; requester 2 re-granted because it is the only one requesting.
2. All 4 requesters continuously valid, full_n_tx=1 -> grant sequence of 4 words each from 0,1,2,3,0...; words_sent=32 after 32 enqueues; bit31 set on every word; no idle cycles.
3. Requester 1 bursting, full_n_tx=0 for 5 cycles after its 2nd word -> d_in_tx held constant; enq_tx=0; req_ready=0; after release, words 3 and 4 are sent and the grant rotates to requester 2.
4. link_up dropped mid-burst with one word registered -> that word is still enqueued once full_n_tx=1; no new accepts while link_up=0; on link_up=1 the next owner is the requester after the interrupted one.
5. RST asserted synchronously while out_vld=1 and full_n_tx=0 -> next cycle enq_tx=0, d_in_tx=0, words_sent=0, state DOWN; the word is never enqueued.
6. Counter wrap: preload via 65535 enqueues, then one more -> words_sent=0x0000.
